// File: rtl/uart_pkg.sv
// Shared types for the uart packet framing path.
// Pulled in by uart_pkt_ctrl and uart_pkt_timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4
  } pkt_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } pkt_err_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte watchdog: counts idle cycles, saturates at LIMIT-1.
// hit fires on an idle cycle that finds the count at the limit.
module uart_pkt_timeout #(
  parameter int LIMIT = 100_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  output logic hit
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] TOP = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + W'(1);
    end
  end

  // an accept on the limit cycle clears instead of flagging
  assign hit = !clr && (cnt == TOP);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Sync-hunting packet framer downstream of uart_rx.
// Define UART_PKT_STATS_EN to add good/bad frame counters.
module uart_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [7:0] pay_data_out,
  output logic       pay_valid_out,
  input  logic       pay_ready_in,
  output logic [7:0] cmd_out,
  output logic [7:0] len_out,
  output logic       done_out,
  output logic [1:0] err_out
`ifdef UART_PKT_STATS_EN
  ,
  output logic [15:0] good_cnt_out,
  output logic [15:0] bad_cnt_out
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  pkt_state_t state;
  logic [7:0] cnt;
  logic [7:0] acc;
  logic [7:0] sum;
  logic       accept;
  logic       to_clr;
  logic       to_hit;

  assign ready_out     = (state == PAYLOAD) ? pay_ready_in : 1'b1;
  assign accept        = valid_in && ready_out;
  assign pay_data_out  = byte_in;
  assign pay_valid_out = valid_in && (state == PAYLOAD);
  assign sum           = acc + byte_in;
  assign to_clr        = (state == HUNT) || accept;

  uart_pkt_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (to_clr),
    .hit    (to_hit)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= HUNT;
      cmd_out  <= '0;
      len_out  <= '0;
      err_out  <= ERR_OK;
      done_out <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      done_out <= 1'b0;
      if (to_hit) begin
        state    <= HUNT;
        done_out <= 1'b1;
        err_out  <= ERR_TIMEOUT;
        cnt      <= '0;
      end else if (accept) begin
        unique case (state)
          HUNT: begin
            if (byte_in == SYNC_BYTE) begin
              state <= CMD;
              acc   <= '0;
            end
          end
          CMD: begin
            cmd_out <= byte_in;
            acc     <= byte_in;
            state   <= LEN;
          end
          LEN: begin
            len_out <= byte_in;
            acc     <= sum;
            cnt     <= '0;
            if (byte_in > MAX_B) begin
              done_out <= 1'b1;
              err_out  <= ERR_LEN;
              state    <= HUNT;
            end else if (byte_in == 8'd0) begin
              state <= CHK;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            acc <= sum;
            if (cnt + 8'd1 == len_out) begin
              cnt   <= '0;
              state <= CHK;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          CHK: begin
            done_out <= 1'b1;
            err_out  <= (sum == 8'd0) ? ERR_OK : ERR_CHK;
            state    <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef UART_PKT_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      good_cnt_out <= '0;
      bad_cnt_out  <= '0;
    end else if (done_out) begin
      if (err_out == ERR_OK) begin
        if (good_cnt_out != 16'hFFFF)
          good_cnt_out <= good_cnt_out + 16'd1;
      end else begin
        if (bad_cnt_out != 16'hFFFF)
          bad_cnt_out <= bad_cnt_out + 16'd1;
      end
    end
  end
`endif

endmodule
